// File: rtl/scene_compositor.sv
// Pipelined pixel compositor for the 800x600 jump game: man, platforms and START/DEAD
// ROM overlays over a per-frame latched scene, with sync delayed to match the RGB path.
module scene_compositor #(
    parameter int NUM_STAGES = 4,
    parameter int COORD_W    = 10,
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 600,
    parameter int STAGE_H    = 100,
    parameter int BODY_HW    = 10,
    parameter int HEAD_OFS   = 15,
    parameter int HEAD_R2    = 100,
    parameter int DEAD_X0    = 200,
    parameter int DEAD_X1    = 600,
    parameter int DEAD_Y0    = 100,
    parameter int DEAD_Y1    = 400,
    parameter int BLINK_BIT  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [COORD_W-1:0]              pix_x,
    input  logic [COORD_W-1:0]              pix_y,
    input  logic                            pix_de,
    input  logic                            in_hs,
    input  logic                            in_vs,
    input  logic                            frame_start,
    input  logic [COORD_W-1:0]              man_x,
    input  logic [COORD_W-1:0]              man_y,
    input  logic [COORD_W-1:0]              man_tall,
    input  logic [NUM_STAGES*COORD_W-1:0]   stage_x,
    input  logic [NUM_STAGES*COORD_W-1:0]   stage_y,
    input  logic [NUM_STAGES*COORD_W-1:0]   stage_w,
    input  logic [NUM_STAGES*2-1:0]         stage_color,
    input  logic [NUM_STAGES-1:0]           stage_en,
    input  logic [3:0]                      state,
    output logic [18:0]                     rom_addr,
    input  logic [2:0]                      rom_start_data,
    input  logic [2:0]                      rom_dead_data,
    output logic                            vga_hs,
    output logic                            vga_vs,
    output logic [3:0]                      vga_r,
    output logic [3:0]                      vga_g,
    output logic [3:0]                      vga_b
);

    localparam int SW        = COORD_W + 2;
    localparam int QW        = 2*COORD_W + 4;
    localparam int PIX_TOTAL = H_ACTIVE * V_ACTIVE;

    localparam logic [3:0]           ST_START  = 4'd0;
    localparam logic [3:0]           ST_DEAD   = 4'd7;
    localparam logic signed [SW-1:0] BODY_HW_S = SW'(BODY_HW);
    localparam logic signed [SW-1:0] HEAD_OFS_S = SW'(HEAD_OFS);
    localparam logic signed [SW-1:0] STAGE_H_S = SW'(STAGE_H);
    localparam logic signed [QW-1:0] HEAD_R2_S = QW'(HEAD_R2);

    function automatic logic signed [SW-1:0] ext(input logic [COORD_W-1:0] v);
        return $signed({2'b00, v});
    endfunction

    function automatic logic signed [SW-1:0] clamp0(input logic signed [SW-1:0] v);
        return v[SW-1] ? '0 : v;
    endfunction

    function automatic logic signed [QW-1:0] widen(input logic signed [SW-1:0] v);
        return $signed({{(QW-SW){v[SW-1]}}, v});
    endfunction

    function automatic logic [11:0] rom_expand(input logic [2:0] d);
        return {{4{d[2]}}, {4{d[1]}}, {4{d[0]}}};
    endfunction

    function automatic logic [11:0] palette(input logic [1:0] c);
        case (c)
            2'b11:   palette = 12'hF00;
            2'b10:   palette = 12'hF70;
            2'b01:   palette = 12'h00F;
            default: palette = 12'h070;
        endcase
    endfunction

    // Scene shadows: only move on frame_start so a frame renders one consistent scene
    logic [COORD_W-1:0]            man_x_sh, man_y_sh, man_tall_sh;
    logic [NUM_STAGES*COORD_W-1:0] stage_x_sh, stage_y_sh, stage_w_sh;
    logic [NUM_STAGES*2-1:0]       stage_color_sh;
    logic [NUM_STAGES-1:0]         stage_en_sh;
    logic [3:0]                    state_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            man_x_sh       <= '0;
            man_y_sh       <= '0;
            man_tall_sh    <= '0;
            stage_x_sh     <= '0;
            stage_y_sh     <= '0;
            stage_w_sh     <= '0;
            stage_color_sh <= '0;
            stage_en_sh    <= '0;
            state_sh       <= '0;
        end else if (frame_start) begin
            man_x_sh       <= man_x;
            man_y_sh       <= man_y;
            man_tall_sh    <= man_tall;
            stage_x_sh     <= stage_x;
            stage_y_sh     <= stage_y;
            stage_w_sh     <= stage_w;
            stage_color_sh <= stage_color;
            stage_en_sh    <= stage_en;
            state_sh       <= state;
        end
    end

    logic [18:0] addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (frame_start) begin
            addr <= '0;
        end else if (pix_de) begin
            addr <= (addr == 19'(PIX_TOTAL - 1)) ? '0 : addr + 19'd1;
        end
    end

    assign rom_addr = addr;

    // Blink counter is held at 0 outside DEAD so the overlay shows on the first DEAD frame
    logic [BLINK_BIT:0] frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (state_sh != ST_DEAD) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // ---- S1: pixel coordinate and sync capture (ROMs sample rom_addr on this edge) ----
    logic [COORD_W-1:0] x_p1, y_p1;
    logic               vld_p1, hs_p1, vs_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_p1   <= '0;
            y_p1   <= '0;
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
        end else begin
            x_p1   <= pix_x;
            y_p1   <= pix_y;
            vld_p1 <= pix_de;
            hs_p1  <= in_hs;
            vs_p1  <= in_vs;
        end
    end

    logic signed [SW-1:0] sx, sy, mx, my, dx, adx, top, hcy, dy;
    logic signed [QW-1:0] dxq, dyq, dist2;
    logic                 body_hit, head_hit, win_hit;

    always_comb begin
        sx       = ext(x_p1);
        sy       = ext(y_p1);
        mx       = ext(man_x_sh);
        my       = ext(man_y_sh);
        dx       = sx - mx;
        adx      = dx[SW-1] ? -dx : dx;
        top      = my - ext(man_tall_sh);
        hcy      = top - HEAD_OFS_S;
        dy       = sy - hcy;
        dxq      = widen(dx);
        dyq      = widen(dy);
        dist2    = dxq * dxq + dyq * dyq;
        body_hit = (adx < BODY_HW_S) && (sy > top) && (sy < my);
        head_hit = dist2 < HEAD_R2_S;
        win_hit  = (x_p1 > COORD_W'(DEAD_X0)) && (x_p1 < COORD_W'(DEAD_X1)) &&
                   (y_p1 > COORD_W'(DEAD_Y0)) && (y_p1 < COORD_W'(DEAD_Y1));
    end

    logic [NUM_STAGES-1:0] stage_hit;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        logic signed [SW-1:0] cx, hw, lft, rgt, st_top, st_bot;
        assign cx     = ext(stage_x_sh[i*COORD_W +: COORD_W]);
        assign hw     = ext(stage_w_sh[i*COORD_W +: COORD_W]);
        assign st_top = ext(stage_y_sh[i*COORD_W +: COORD_W]);
        assign lft    = clamp0(cx - hw);
        assign rgt    = cx + hw;
        assign st_bot = st_top + STAGE_H_S;
        assign stage_hit[i] = stage_en_sh[i] && (sx > lft) && (sx < rgt) &&
                              (sy > st_top) && (sy < st_bot);
    end

    logic       stage_any;
    logic [1:0] stage_col;

    // Walk downward so the lowest-index hit is the last one written
    always_comb begin
        stage_any = 1'b0;
        stage_col = 2'b00;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (stage_hit[i]) begin
                stage_any = 1'b1;
                stage_col = stage_color_sh[i*2 +: 2];
            end
        end
    end

    // ---- S2: hit flags and ROM data ----
    logic       vld_p2, hs_p2, vs_p2, man_p2, stage_any_p2, win_p2;
    logic [1:0] stage_col_p2;
    logic [2:0] start_p2, dead_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2       <= 1'b0;
            hs_p2        <= 1'b0;
            vs_p2        <= 1'b0;
            man_p2       <= 1'b0;
            stage_any_p2 <= 1'b0;
            stage_col_p2 <= '0;
            win_p2       <= 1'b0;
            start_p2     <= '0;
            dead_p2      <= '0;
        end else begin
            vld_p2       <= vld_p1;
            hs_p2        <= hs_p1;
            vs_p2        <= vs_p1;
            man_p2       <= body_hit | head_hit;
            stage_any_p2 <= stage_any;
            stage_col_p2 <= stage_col;
            win_p2       <= win_hit;
            start_p2     <= rom_start_data;
            dead_p2      <= rom_dead_data;
        end
    end

    logic [11:0] rgb_next;

    always_comb begin
        rgb_next = 12'h000;
        if (!vld_p2) begin
            rgb_next = 12'h000;
        end else if (state_sh == ST_START) begin
            rgb_next = rom_expand(start_p2);
        end else if (state_sh == ST_DEAD && !frame_cnt[BLINK_BIT] && win_p2 &&
                     dead_p2 != 3'b000) begin
            rgb_next = rom_expand(dead_p2);
        end else if (man_p2) begin
            rgb_next = 12'hFFF;
        end else if (stage_any_p2) begin
            rgb_next = palette(stage_col_p2);
        end
    end

    // ---- Output registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hs <= 1'b0;
            vga_vs <= 1'b0;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else begin
            vga_hs <= hs_p2;
            vga_vs <= vs_p2;
            {vga_r, vga_g, vga_b} <= rgb_next;
        end
    end

endmodule

// File: tb/tb_scene_compositor.sv
// Directed bench for scene_compositor: man/head hits, platform priority and palette,
// frame-latched shadows, START ROM addressing, DEAD overlay blink and mid-line reset.
module tb_scene_compositor;

    localparam int NS = 4;
    localparam int CW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [CW-1:0]     pix_x, pix_y, man_x, man_y, man_tall;
    logic              pix_de, in_hs, in_vs, frame_start;
    logic [NS*CW-1:0]  stage_x, stage_y, stage_w;
    logic [NS*2-1:0]   stage_color;
    logic [NS-1:0]     stage_en;
    logic [3:0]        state;
    logic [18:0]       rom_addr;
    logic [2:0]        rom_start_data, rom_dead_data, dead_val;
    logic              vga_hs, vga_vs;
    logic [3:0]        vga_r, vga_g, vga_b;
    logic [11:0]       rgb, c;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    scene_compositor dut (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de),
        .in_hs(in_hs), .in_vs(in_vs), .frame_start(frame_start),
        .man_x(man_x), .man_y(man_y), .man_tall(man_tall),
        .stage_x(stage_x), .stage_y(stage_y), .stage_w(stage_w),
        .stage_color(stage_color), .stage_en(stage_en), .state(state),
        .rom_addr(rom_addr), .rom_start_data(rom_start_data), .rom_dead_data(rom_dead_data),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    assign rgb = {vga_r, vga_g, vga_b};

    function automatic logic [2:0] rom_fn(input logic [18:0] a);
        return a[2:0] ^ a[5:3];
    endfunction

    function automatic logic [11:0] exp3(input logic [2:0] d);
        return {{4{d[2]}}, {4{d[1]}}, {4{d[0]}}};
    endfunction

    // Synchronous 1-cycle ROM models
    always @(posedge clk) begin
        rom_start_data <= rom_fn(rom_addr);
        rom_dead_data  <= dead_val;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic probe(input int x, input int y, output logic [11:0] col);
        pix_x  = CW'(x);
        pix_y  = CW'(y);
        pix_de = 1'b1;
        step();
        pix_de = 1'b0;
        step();
        step();
        col = rgb;
    endtask

    task automatic set_stage(input int i, input int x, input int y, input int w,
                             input logic [1:0] col);
        stage_x[i*CW +: CW]   = CW'(x);
        stage_y[i*CW +: CW]   = CW'(y);
        stage_w[i*CW +: CW]   = CW'(w);
        stage_color[i*2 +: 2] = col;
        stage_en[i]           = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pix_x = '0; pix_y = '0; pix_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0;
        frame_start = 1'b0; man_x = '0; man_y = '0; man_tall = '0;
        stage_x = '0; stage_y = '0; stage_w = '0; stage_color = '0; stage_en = '0;
        state = 4'd0; dead_val = 3'b000;
        repeat (3) step();
        vectors++;
        if (rgb !== 12'h000) begin miscompares++; $display("FAIL reset_rgb got %h want 000", rgb); end
        vectors++;
        if ({vga_hs, vga_vs} !== 2'b00) begin miscompares++; $display("FAIL reset_sync got %b want 00", {vga_hs, vga_vs}); end
        vectors++;
        if (rom_addr !== 19'd0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_man();
        man_x = 10'd400; man_y = 10'd500; man_tall = 10'd40; state = 4'd1; stage_en = '0;
        pulse_frame();
        pix_x = 10'd400; pix_y = 10'd480; pix_de = 1'b1; in_hs = 1'b1; in_vs = 1'b1;
        step();
        pix_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0;
        step();
        vectors++;
        if (rgb !== 12'h000 || vga_hs !== 1'b0) begin miscompares++; $display("FAIL man_early got %h/%b want 000/0", rgb, vga_hs); end
        step();
        vectors++;
        if (rgb !== 12'hFFF) begin miscompares++; $display("FAIL man_body_lat2 got %h want FFF", rgb); end
        vectors++;
        if ({vga_hs, vga_vs} !== 2'b11) begin miscompares++; $display("FAIL sync_lat2 got %b want 11", {vga_hs, vga_vs}); end
        probe(400, 445, c);
        vectors++;
        if (c !== 12'hFFF) begin miscompares++; $display("FAIL man_head got %h want FFF", c); end
        probe(411, 480, c);
        vectors++;
        if (c !== 12'h000) begin miscompares++; $display("FAIL man_right_out got %h want 000", c); end
        probe(409, 480, c);
        vectors++;
        if (c !== 12'hFFF) begin miscompares++; $display("FAIL man_right_in got %h want FFF", c); end
        probe(400, 500, c);
        vectors++;
        if (c !== 12'h000) begin miscompares++; $display("FAIL man_feet got %h want 000", c); end
        probe(409, 445, c);
        vectors++;
        if (c !== 12'hFFF) begin miscompares++; $display("FAIL head_r81 got %h want FFF", c); end
        probe(410, 445, c);
        vectors++;
        if (c !== 12'h000) begin miscompares++; $display("FAIL head_r100 got %h want 000", c); end
    endtask

    task automatic test_stages();
        set_stage(0, 50, 500, 80, 2'b10);
        set_stage(1, 60, 500, 100, 2'b01);
        set_stage(2, 700, 300, 50, 2'b11);
        set_stage(3, 700, 100, 50, 2'b00);
        pulse_frame();
        probe(10, 550, c);
        vectors++;
        if (c !== 12'hF70) begin miscompares++; $display("FAIL stage_prio got %h want F70", c); end
        probe(0, 550, c);
        vectors++;
        if (c !== 12'h000) begin miscompares++; $display("FAIL stage_clamp got %h want 000", c); end
        probe(140, 550, c);
        vectors++;
        if (c !== 12'h00F) begin miscompares++; $display("FAIL stage1_only got %h want 00F", c); end
        probe(10, 500, c);
        vectors++;
        if (c !== 12'h000) begin miscompares++; $display("FAIL stage_top got %h want 000", c); end
        probe(10, 599, c);
        vectors++;
        if (c !== 12'hF70) begin miscompares++; $display("FAIL stage_bot_in got %h want F70", c); end
        probe(10, 600, c);
        vectors++;
        if (c !== 12'h000) begin miscompares++; $display("FAIL stage_bot_out got %h want 000", c); end
        probe(700, 350, c);
        vectors++;
        if (c !== 12'hF00) begin miscompares++; $display("FAIL pal_11 got %h want F00", c); end
        probe(700, 150, c);
        vectors++;
        if (c !== 12'h070) begin miscompares++; $display("FAIL pal_00 got %h want 070", c); end
        stage_en = 4'b0011;
        pulse_frame();
        probe(700, 350, c);
        vectors++;
        if (c !== 12'h000) begin miscompares++; $display("FAIL stage_disabled got %h want 000", c); end
    endtask

    task automatic test_shadow();
        stage_x[0 +: CW] = 10'd300;
        probe(10, 550, c);
        vectors++;
        if (c !== 12'hF70) begin miscompares++; $display("FAIL shadow_hold got %h want F70", c); end
        pulse_frame();
        probe(10, 550, c);
        vectors++;
        if (c !== 12'h00F) begin miscompares++; $display("FAIL shadow_new_a got %h want 00F", c); end
        probe(300, 550, c);
        vectors++;
        if (c !== 12'hF70) begin miscompares++; $display("FAIL shadow_new_b got %h want F70", c); end
    endtask

    task automatic test_start_rom();
        state = 4'd0;
        pulse_frame();
        for (int i = 0; i < 803; i++) begin
            if (i < 800) begin
                vectors++;
                if (rom_addr !== 19'(i)) begin miscompares++; $display("FAIL start_addr got %0d want %0d", rom_addr, i); end
                pix_de = 1'b1;
                pix_x  = CW'(i);
                pix_y  = '0;
            end else begin
                pix_de = 1'b0;
            end
            if (i >= 3) begin
                vectors++;
                if (rgb !== exp3(rom_fn(19'(i - 3)))) begin
                    miscompares++;
                    $display("FAIL start_rgb px %0d got %h want %h", i - 3, rgb, exp3(rom_fn(19'(i - 3))));
                end
            end
            step();
        end
        vectors++;
        if (rom_addr !== 19'd800) begin miscompares++; $display("FAIL start_addr_end got %0d want 800", rom_addr); end
        pulse_frame();
        vectors++;
        if (rom_addr !== 19'd0) begin miscompares++; $display("FAIL start_addr_clr got %0d want 0", rom_addr); end
    endtask

    task automatic test_dead();
        state = 4'd7; stage_en = '0; man_x = 10'd400; man_y = 10'd300; man_tall = 10'd40;
        dead_val = 3'b101;
        pulse_frame();
        probe(300, 300, c);
        vectors++;
        if (c !== 12'hF0F) begin miscompares++; $display("FAIL dead_in got %h want F0F", c); end
        probe(199, 300, c);
        vectors++;
        if (c !== 12'h000) begin miscompares++; $display("FAIL dead_199 got %h want 000", c); end
        probe(200, 300, c);
        vectors++;
        if (c !== 12'h000) begin miscompares++; $display("FAIL dead_200 got %h want 000", c); end
        probe(201, 300, c);
        vectors++;
        if (c !== 12'hF0F) begin miscompares++; $display("FAIL dead_201 got %h want F0F", c); end
        probe(400, 280, c);
        vectors++;
        if (c !== 12'hF0F) begin miscompares++; $display("FAIL dead_over_man got %h want F0F", c); end
        dead_val = 3'b000;
        probe(400, 280, c);
        vectors++;
        if (c !== 12'hFFF) begin miscompares++; $display("FAIL dead_zero_man got %h want FFF", c); end
        dead_val = 3'b101;
        repeat (15) pulse_frame();
        probe(300, 300, c);
        vectors++;
        if (c !== 12'hF0F) begin miscompares++; $display("FAIL blink_f15 got %h want F0F", c); end
        pulse_frame();
        probe(300, 300, c);
        vectors++;
        if (c !== 12'h000) begin miscompares++; $display("FAIL blink_f16 got %h want 000", c); end
        probe(400, 280, c);
        vectors++;
        if (c !== 12'hFFF) begin miscompares++; $display("FAIL blink_f16_man got %h want FFF", c); end
        repeat (15) pulse_frame();
        probe(300, 300, c);
        vectors++;
        if (c !== 12'h000) begin miscompares++; $display("FAIL blink_f31 got %h want 000", c); end
        pulse_frame();
        probe(300, 300, c);
        vectors++;
        if (c !== 12'hF0F) begin miscompares++; $display("FAIL blink_wrap got %h want F0F", c); end
        repeat (20) pulse_frame();
        state = 4'd1;
        pulse_frame();
        state = 4'd7;
        pulse_frame();
        probe(300, 300, c);
        vectors++;
        if (c !== 12'hF0F) begin miscompares++; $display("FAIL dead_reenter got %h want F0F", c); end
    endtask

    task automatic test_reset_midline();
        state = 4'd1; man_x = 10'd400; man_y = 10'd500; man_tall = 10'd40; stage_en = '0;
        pulse_frame();
        pix_x = 10'd400; pix_y = 10'd480; pix_de = 1'b1; in_hs = 1'b1; in_vs = 1'b1;
        repeat (3) step();
        vectors++;
        if (rgb !== 12'hFFF || vga_hs !== 1'b1) begin miscompares++; $display("FAIL pre_reset got %h/%b want FFF/1", rgb, vga_hs); end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (rgb !== 12'h000 || {vga_hs, vga_vs} !== 2'b00) begin miscompares++; $display("FAIL async_reset got %h/%b want 000/00", rgb, {vga_hs, vga_vs}); end
        vectors++;
        if (rom_addr !== 19'd0) begin miscompares++; $display("FAIL async_reset_addr got %0d want 0", rom_addr); end
        pix_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0;
        step();
        rst = 1'b0;
        step();
        probe(400, 480, c);
        vectors++;
        if (c !== 12'h000) begin miscompares++; $display("FAIL post_reset_black got %h want 000", c); end
        pulse_frame();
        probe(400, 480, c);
        vectors++;
        if (c !== 12'hFFF) begin miscompares++; $display("FAIL post_reset_frame got %h want FFF", c); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_man();
        test_stages();
        test_shadow();
        test_start_rom();
        test_dead();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
